ram_loader: RTL and testbench

- Writer-side counterpart of the read-only instruction/data memory.
- Accepts a byte stream (e.g. from the UART receiver), frames it, assembles 32-bit little-endian words and drives one write port of the dual-port RAM.
- Holds the core in reset while loading and reports done or error.
- Sits between the serial receiver and the RAM write port; the core fetches through the other port after `done`.

---
 rtl/ram_loader_pkg.sv | 18 +
 rtl/loader_word_asm.sv | 55 +++++
 rtl/ram_loader.sv | 145 ++++++++++++++
 tb/tb_ram_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared encodings for the RAM loader: FSM states, write-enable patterns,
// and the size of the frame length field.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_SUM  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [3:0] WE_ALL    = 4'hF;
    localparam logic [3:0] WE_NONE   = 4'h0;
    localparam int         LEN_BYTES = 4;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler for the RAM loader. Collects little-endian bytes,
// keeps the running mod-256 checksum of payload bytes and emits one
// registered word_valid pulse per completed payload word.
module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic        data_phase,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic [31:0] next_word,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  checksum
);

    logic [23:0] shreg;
    logic [1:0]  cnt;

    // The word that completes if the byte on byte_in is accepted now; the
    // FSM uses it to decode the length field without an extra cycle.
    assign last_byte = (cnt == 2'd3);
    assign next_word = {byte_in, shreg};

    // Shift in accepted bytes (first byte ends up in bits [7:0]), count
    // them, accumulate payload bytes and strobe completed payload words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            cnt        <= '0;
            checksum   <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shreg    <= '0;
                cnt      <= '0;
                checksum <= '0;
            end else if (accept) begin
                shreg <= {byte_in, shreg[23:8]};
                cnt   <= cnt + 2'd1;
                if (data_phase) begin
                    checksum <= checksum + byte_in;
                    if (last_byte) begin
                        word_valid <= 1'b1;
                        word       <= next_word;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Frame-based RAM loader: LEN(4B LE) | N words (LE) | SUM(1B). Writes the
// payload through one RAM write port and holds the core in reset until a
// load completes with a matching checksum.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int SCALE   = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [3:0]       we,
    output logic [SCALE-1:0] addr,
    output logic [31:0]      wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   IDLE_LIMIT = TW'(TIMEOUT - 1);
    localparam logic [32:0]     CAPACITY   = 33'd1 << SCALE;

    state_t           state;
    logic [SCALE:0]   idx;
    logic [SCALE:0]   idx_next;
    logic [SCALE:0]   n_words;
    logic [TW-1:0]    idle_cnt;
    logic             accept;
    logic             load_go;
    logic             last_byte;
    logic [31:0]      next_word;
    logic             word_valid;
    logic [7:0]       checksum;

    assign accept   = in_valid && in_ready;
    assign load_go  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign idx_next = idx + 1'b1;

    // The write strobe is the assembler's registered word pulse, so it lands
    // one cycle after the 4th byte and vanishes with the async reset.
    assign we = word_valid ? WE_ALL : WE_NONE;

    loader_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_go),
        .accept     (accept),
        .data_phase (state == S_DATA),
        .byte_in    (in_data),
        .last_byte  (last_byte),
        .next_word  (next_word),
        .word_valid (word_valid),
        .word       (wdata),
        .checksum   (checksum)
    );

    // Frame FSM with registered status outputs and the idle timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            idx      <= '0;
            n_words  <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        in_ready <= 1'b1;
                        idx      <= '0;
                        idle_cnt <= '0;
                    end
                end
                default: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        case (state)
                            S_LEN: begin
                                if (last_byte) begin
                                    if ({1'b0, next_word} > CAPACITY) begin
                                        state    <= S_ERR;
                                        busy     <= 1'b0;
                                        error    <= 1'b1;
                                        in_ready <= 1'b0;
                                    end else if (next_word == 32'd0) begin
                                        state <= S_SUM;
                                    end else begin
                                        state   <= S_DATA;
                                        n_words <= next_word[SCALE:0];
                                    end
                                end
                            end
                            S_DATA: begin
                                if (last_byte) begin
                                    addr <= idx[SCALE-1:0];
                                    idx  <= idx_next;
                                    if (idx_next == n_words)
                                        state <= S_SUM;
                                end
                            end
                            S_SUM: begin
                                busy     <= 1'b0;
                                in_ready <= 1'b0;
                                if (in_data == checksum) begin
                                    state    <= S_DONE;
                                    done     <= 1'b1;
                                    cpu_hold <= 1'b0;
                                end else begin
                                    state <= S_ERR;
                                    error <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (idle_cnt == IDLE_LIMIT) begin
                        // Stalled too long mid-frame: abort; any partial word is discarded.
                        state    <= S_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader (SCALE=4, TIMEOUT=16): expected RAM
// writes are queued as bytes are driven and checked as strobes appear.
module tb_ram_loader;

    localparam int SCALE   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic [3:0]       we;
    logic [SCALE-1:0] addr;
    logic [31:0]      wdata;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             error;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;
    int stalls   = 0;

    logic [35:0] exp_q [$];
    logic [31:0] wbuf [0:15];

    ram_loader #(.SCALE(SCALE), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && we !== 4'h0) begin
            writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {60'd0, we}, 64'd0);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("we", {60'd0, we}, 64'hF);
                chk("waddr", {60'd0, addr}, {60'd0, e[35:32]});
                chk("wdata", {32'd0, wdata}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    // Sends a full frame from wbuf; bad=1 corrupts the checksum byte.
    task automatic send_frame(input int n, input bit bad);
        logic [7:0] s = 8'd0;
        logic [31:0] w;
        logic [3:0]  a;
        send_len(n);
        for (int k = 0; k < n; k++) begin
            w = wbuf[k];
            a = k[3:0];
            exp_q.push_back({a, w});
            for (int i = 0; i < 4; i++) begin
                send_byte(w[8*i +: 8]);
                s = s + w[8*i +: 8];
            end
        end
        send_byte(bad ? s + 8'd1 : s);
    endtask

    task automatic chk_status(input string tag, input bit d, input bit e);
        @(negedge clk);
        chk({tag, "_done"},  {63'd0, done},     {63'd0, d});
        chk({tag, "_error"}, {63'd0, error},    {63'd0, e});
        chk({tag, "_hold"},  {63'd0, cpu_hold}, {63'd0, !d});
        chk({tag, "_busy"},  {63'd0, busy},     64'd0);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_q"},     exp_q.size(),      64'd0);
    endtask

    initial begin
        int w0;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {60'd0, we}, 64'd0);
        chk("rst_addr", {60'd0, addr}, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_status", {60'd0, busy, done, error, cpu_hold}, 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic two-word frame, with an ignored start pulse mid-frame.
        wbuf[0] = 32'h12345678;
        wbuf[1] = 32'hDEADBEEF;
        pulse_start();
        @(negedge clk);
        chk("start_busy", {62'd0, busy, in_ready}, 64'h3);
        @(posedge clk); #1;
        send_byte(8'h02);
        send_byte(8'h00);
        start = 1'b1;
        send_byte(8'h00);
        start = 1'b0;
        send_byte(8'h00);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({k[3:0], wbuf[k]});
            for (int i = 0; i < 4; i++) send_byte(wbuf[k][8*i +: 8]);
        end
        send_byte(8'h4C);
        chk_status("ok2", 1'b1, 1'b0);
        chk("ok2_writes", writes, 64'd2);

        // Same frame, bad checksum: writes still happen, then error.
        pulse_start();
        send_frame(2, 1'b1);
        chk_status("badsum", 1'b0, 1'b1);
        chk("badsum_writes", writes, 64'd4);

        // Empty frame.
        pulse_start();
        send_len(0);
        send_byte(8'h00);
        chk_status("len0", 1'b1, 1'b0);

        // Oversized lengths abort right after the length field.
        pulse_start();
        send_len(1025);
        chk_status("len1025", 1'b0, 1'b1);
        pulse_start();
        send_len(17);
        chk_status("len17", 1'b0, 1'b1);
        chk("oversize_writes", writes, 64'd4);

        // Timeout mid-word: no partial write.
        pulse_start();
        send_len(1);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("to_early", {63'd0, error}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("to_error", {62'd0, error, busy}, 64'h2);
        chk("to_writes", writes, 64'd4);
        wbuf[0] = 32'hCAFEF00D;
        pulse_start();
        send_frame(1, 1'b0);
        chk_status("after_to", 1'b1, 1'b0);

        // Full-capacity back-to-back stream.
        for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
        w0 = writes;
        pulse_start();
        stalls = 0;
        send_frame(16, 1'b0);
        chk("stream_stalls", stalls, 64'd0);
        chk_status("stream", 1'b1, 1'b0);
        chk("stream_writes", writes - w0, 64'd16);

        // Reset on the cycle the first write strobe fires.
        wbuf[0] = 32'hA5A55A5A;
        pulse_start();
        send_len(2);
        for (int i = 0; i < 4; i++) send_byte(wbuf[0][8*i +: 8]);
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_we", {60'd0, we}, 64'd0);
        chk("mid_rst_addr", {60'd0, addr}, 64'd0);
        chk("mid_rst_wdata", {32'd0, wdata}, 64'd0);
        chk("mid_rst_status", {59'd0, in_ready, busy, done, error, cpu_hold}, 64'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        w0 = writes;
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_writes", writes - w0, 64'd0);
        wbuf[0] = 32'h01020304;
        wbuf[1] = 32'hFFFFFFFF;
        pulse_start();
        send_frame(2, 1'b0);
        chk_status("post_rst", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
